uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter; legal range is 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: byte width, equal to the transmitter's DATA_WIDTH.
REQ-003 Parameter CLOCKS_PER_BIT, default 10417: equal to the transmitter's setting (100 MHz clock, 9600 baud).
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester transmit request, level-sensitive.
REQ-007 reqData  input  NUM_REQ*DATA_WIDTH  requester i's byte at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 grant  output  NUM_REQ  one-hot, one-cycle pulse: the requester's byte has been taken.
REQ-009 txWrEn  output  1  drives the transmitter's wrEn.
REQ-010 txData  output  DATA_WIDTH  drives the transmitter's dataIn.
REQ-011 txNewTXN  output  1  drives the transmitter's newTXN.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have states IDLE, LOAD, KICK and WAIT.
REQ-015 IDLE: with req!=0, the winner w SHALL be picked round-robin starting from pointer ptr, then searching upward with wrap.
  - Next edge: state goes to LOAD.
  - Same edge: grant[w]=1, txWrEn=1, txData=reqData slice w.
REQ-016 LOAD -> KICK unconditionally.
  - On that edge: grant=0, txWrEn=0, txNewTXN=1.
REQ-017 KICK -> WAIT unconditionally.
  - On that edge: txNewTXN=0, frame timer=0.
REQ-018 WAIT: the frame timer SHALL count to FRAME_CLOCKS-1, where FRAME_CLOCKS=(DATA_WIDTH+2)*CLOCKS_PER_BIT, then go to IDLE.
  - Timer width: $clog2(FRAME_CLOCKS).
REQ-019 ptr SHALL be set to (w+1) mod NUM_REQ on the grant edge.
REQ-020 Request-to-grant latency SHALL be 1 cycle from IDLE.
  - Back-to-back grant spacing SHALL be exactly FRAME_CLOCKS+3 cycles.
REQ-021 Requests arriving outside IDLE SHALL be ignored until the return to IDLE; nothing is queued internally.
REQ-022 A req dropped before its grant SHALL be withdrawn with no side effect.
REQ-023 reqData SHALL be sampled only on the grant edge; later changes SHALL NOT affect txData.
REQ-024 Simultaneous requests SHALL yield exactly one grant per frame.
  - No requester SHALL wait more than NUM_REQ-1 frames while holding req.
REQ-025 A requester holding req after its grant SHALL be treated as a new request (next byte).
REQ-026 txData SHALL hold its value until the next grant.

Reset
REQ-027 Reset SHALL force the following, whether idle or mid-frame:
  - state=IDLE, ptr=0, timer=0
  - grant=0, txWrEn=0, txNewTXN=0, busy=0, txData=0
REQ-028 After reset release, the first request SHALL be evaluated on the first rising edge.

Structure
REQ-029 Package uart_pkg SHALL hold:
  - the arbiter state encoding (2 bits);
  - a FRAME_CLOCKS constant function of DATA_WIDTH and CLOCKS_PER_BIT, shared with the transmitter.
REQ-030 A sub-module rr_pick SHALL be used:
  - combinational;
  - inputs req and ptr; outputs a one-hot winner and a valid flag.
REQ-031 The FSM, timer, ptr and output registers SHALL live in uart_tx_arbiter.

Verification (CLOCKS_PER_BIT=4, DATA_WIDTH=8, NUM_REQ=4, FRAME_CLOCKS=40)
REQ-032 Single request:
  - Stimulus: req=0010, slice1=0xA5.
  - Response: grant=0010 one cycle later, together with txWrEn=1 and txData=0xA5; txNewTXN=1 on the next cycle; busy high for 42 cycles.
REQ-033 All four requesting continuously, ptr=0:
  - Grants SHALL occur in order 0,1,2,3,0, with spacing 43 cycles.
REQ-034 Data change after grant:
  - Stimulus: reqData slice altered the cycle after grant.
  - Response: txData holds the granted byte.
REQ-035 Request withdrawn:
  - Stimulus: req[2] pulses for 5 cycles during WAIT.
  - Response: no grant to requester 2; the arbiter returns to IDLE with busy=0.
REQ-036 Reset mid-frame:
  - Stimulus: rst asserted at WAIT timer=17.
  - Response: all outputs 0 immediately (asynchronous); after release, req=1000 is granted after 1 cycle, requester 3 first since ptr=0.
REQ-037 Late request:
  - Stimulus: req=0001 asserted in KICK.
  - Response: no grant until the timer wraps; grant issued on the first IDLE cycle.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared definitions for the UART transmit path: arbiter state
//            encoding and the frame-length helper used by arbiter and
//            transmitter alike.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Arbiter FSM state encoding (2 bits)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_KICK = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    // Clocks in one serial frame: start bit + data bits + stop bit
    function automatic int frame_clocks(input int data_width, input int clocks_per_bit);
        return (data_width + 2) * clocks_per_bit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker. Searches req upward from ptr
//            with wrap-around and returns a one-hot winner plus valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic               valid_o
);

    localparam int PW1 = PW + 1;

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;
    logic          w_found;

    // First requester at or above ptr (modulo NUM_REQ) wins
    always_comb begin
        winner_o = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, ptr_i} + PW1'(k);
            if (w_sum >= PW1'(NUM_REQ)) begin
                w_sum = w_sum - PW1'(NUM_REQ);
            end
            w_idx = w_sum[PW-1:0];
            if (!w_found && req_i[w_idx]) begin
                winner_o[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
        valid_o = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Shares one UART transmitter among NUM_REQ requesters. A byte is
//            taken round-robin in IDLE, written to the transmitter (LOAD),
//            started (KICK) and the arbiter then waits one full frame (WAIT)
//            before accepting the next request.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int CLOCKS_PER_BIT = 10417
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          txWrEn,
    output logic [DATA_WIDTH-1:0]         txData,
    output logic                          txNewTXN,
    output logic                          busy
);

    localparam int FRAME_CLOCKS = frame_clocks(DATA_WIDTH, CLOCKS_PER_BIT);
    localparam int TW           = $clog2(FRAME_CLOCKS);
    localparam int PW           = $clog2(NUM_REQ);

    logic [1:0]            state_q,  state_d;
    logic [PW-1:0]         ptr_q,    ptr_d;
    logic [TW-1:0]         timer_q,  timer_d;
    logic [NUM_REQ-1:0]    grant_q,  grant_d;
    logic                  wren_q,   wren_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic                  newtxn_q, newtxn_d;
    logic                  busy_q,   busy_d;

    logic [NUM_REQ-1:0]    win_onehot;
    logic                  win_valid;
    logic [PW-1:0]         win_idx;
    logic [PW-1:0]         ptr_next;
    logic [DATA_WIDTH-1:0] win_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (win_onehot),
        .valid_o  (win_valid)
    );

    // Decode the one-hot winner into an index and select its byte
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_idx  = PW'(i);
                win_data = reqData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        ptr_next = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // Next-state logic; strobes default low so grant/wrEn/newTXN are pulses
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        timer_d  = timer_q;
        grant_d  = '0;
        wren_d   = 1'b0;
        newtxn_d = 1'b0;
        data_d   = data_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_LOAD;
                    grant_d = win_onehot;
                    wren_d  = 1'b1;
                    data_d  = win_data;
                    ptr_d   = ptr_next;
                end
            end
            ST_LOAD: begin
                state_d  = ST_KICK;
                newtxn_d = 1'b1;
            end
            ST_KICK: begin
                state_d = ST_WAIT;
                timer_d = '0;
            end
            ST_WAIT: begin
                if (timer_q == TW'(FRAME_CLOCKS - 1)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared asynchronously at any point in a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            timer_q  <= '0;
            grant_q  <= '0;
            wren_q   <= 1'b0;
            data_q   <= '0;
            newtxn_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
            grant_q  <= grant_d;
            wren_q   <= wren_d;
            data_q   <= data_d;
            newtxn_q <= newtxn_d;
            busy_q   <= busy_d;
        end
    end

    assign grant    = grant_q;
    assign txWrEn   = wren_q;
    assign txData   = data_q;
    assign txNewTXN = newtxn_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter with
//            NUM_REQ=4, DATA_WIDTH=8, CLOCKS_PER_BIT=4 (frame = 40 clocks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int DATA_WIDTH     = 8;
    localparam int CLOCKS_PER_BIT = 4;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0]            grant;
    logic                          txWrEn;
    logic [DATA_WIDTH-1:0]         txData;
    logic                          txNewTXN;
    logic                          busy;

    int n_checks;
    int n_errors;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_WIDTH     (DATA_WIDTH),
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .reqData  (reqData),
        .grant    (grant),
        .txWrEn   (txWrEn),
        .txData   (txData),
        .txNewTXN (txNewTXN),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; samples taken 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},  32'(grant),    32'd0);
        check({tag, "_wren"},   32'(txWrEn),   32'd0);
        check({tag, "_data"},   32'(txData),   32'd0);
        check({tag, "_newtxn"}, 32'(txNewTXN), 32'd0);
        check({tag, "_busy"},   32'(busy),     32'd0);
    endtask

    logic [3:0] g_seen [5];
    logic [7:0] d_seen [5];
    int         t_seen [5];

    initial begin
        int cnt;
        int ng;
        int cyc;
        int gcnt;

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        req      = '0;
        reqData  = '0;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Single request, data changed after grant, busy length
        reqData[15:8] = 8'hA5;
        req           = 4'b0010;
        tick();
        check("single_grant",  32'(grant),    32'h2);
        check("single_wren",   32'(txWrEn),   32'd1);
        check("single_data",   32'(txData),   32'hA5);
        check("single_busy",   32'(busy),     32'd1);
        check("single_newtxn0", 32'(txNewTXN), 32'd0);
        req           = '0;
        reqData[15:8] = 8'h3C;
        tick();
        check("kick_newtxn",   32'(txNewTXN), 32'd1);
        check("kick_grant",    32'(grant),    32'd0);
        check("kick_wren",     32'(txWrEn),   32'd0);
        check("kick_data",     32'(txData),   32'hA5);
        cnt = 2;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (busy) cnt++;
            else break;
        end
        check("busy_cycles",   32'(cnt),      32'd42);
        check("data_hold",     32'(txData),   32'hA5);

        // Reset from idle puts ptr back to 0, then all four request continuously
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        reqData = {8'h13, 8'h12, 8'h11, 8'h10};
        req     = 4'hF;
        ng  = 0;
        cyc = 0;
        while (ng < 5 && cyc < 300) begin
            tick();
            cyc++;
            if (grant != 0) begin
                g_seen[ng] = grant;
                d_seen[ng] = txData;
                t_seen[ng] = cyc;
                ng++;
            end
        end
        req = '0;
        check("rr_count", 32'(ng), 32'd5);
        if (ng == 5) begin
            check("rr_first_latency", 32'(t_seen[0]), 32'd1);
            check("rr_g0", 32'(g_seen[0]), 32'h1);
            check("rr_g1", 32'(g_seen[1]), 32'h2);
            check("rr_g2", 32'(g_seen[2]), 32'h4);
            check("rr_g3", 32'(g_seen[3]), 32'h8);
            check("rr_g4", 32'(g_seen[4]), 32'h1);
            check("rr_d1", 32'(d_seen[1]), 32'h11);
            check("rr_d3", 32'(d_seen[3]), 32'h13);
            for (int k = 1; k < 5; k++) begin
                check("rr_spacing", 32'(t_seen[k] - t_seen[k-1]), 32'd43);
            end
        end
        wait_idle("rr_idle");

        // Request pulsed during WAIT and withdrawn is never granted
        req = 4'b0001;
        tick();
        check("wd_grant0", 32'(grant), 32'h1);
        req = '0;
        repeat (10) tick();
        req = 4'b0100;
        gcnt = 0;
        repeat (5) begin
            tick();
            if (grant != 0) gcnt++;
        end
        req = '0;
        cnt = 0;
        while (busy && cnt < 200) begin
            tick();
            cnt++;
            if (grant != 0) gcnt++;
        end
        check("wd_busy", 32'(busy), 32'd0);
        tick();
        if (grant != 0) gcnt++;
        check("wd_no_grant", 32'(gcnt), 32'd0);

        // Request asserted in KICK waits for the frame, then granted in first IDLE cycle
        req = 4'b0001;
        tick();
        check("late_grant0", 32'(grant), 32'h1);
        req = '0;
        tick();
        check("late_in_kick", 32'(txNewTXN), 32'd1);
        req = 4'b0001;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cnt++;
            if (grant != 0) break;
        end
        req = '0;
        check("late_delay", 32'(cnt),   32'd42);
        check("late_grant", 32'(grant), 32'h1);
        wait_idle("late_idle");

        // Asynchronous reset at WAIT timer=17
        reqData[7:0] = 8'h5A;
        req = 4'b0001;
        tick();
        check("mid_grant", 32'(grant), 32'h1);
        req = '0;
        repeat (19) tick();
        check("mid_busy",  32'(busy),   32'd1);
        check("mid_data",  32'(txData), 32'h5A);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        rst = 1'b0;
        reqData[31:24] = 8'hC3;
        req = 4'b1000;
        tick();
        check("post_rst_grant", 32'(grant),  32'h8);
        check("post_rst_data",  32'(txData), 32'hC3);
        check("post_rst_wren",  32'(txWrEn), 32'd1);
        req = '0;
        wait_idle("post_rst_idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
